// File: rtl/lcm_pkg.sv
// Shared definitions for the GCD/LCM sequencer: FSM state encoding and
// the default operand width.
package lcm_pkg;

    // Default operand / gcd width; lcm is twice this.
    localparam int LCM_DATA_WIDTH = 8;

    // Sequencer states: accept, Euclid remainder loop, a/gcd quotient,
    // final multiply, result presentation.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        EUC  = 3'd1,
        QUO  = 3'd2,
        MUL  = 3'd3,
        DONE = 3'd4
    } lcm_state_t;

endpackage

// File: rtl/lcm_seq_div.sv
// Combinational unsigned integer divider (restoring, one stage per
// quotient bit). Result for a zero denominator is not meaningful; the
// sequencer never presents one.
module lcm_seq_div #(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] numer,
    input  logic [DATA_WIDTH-1:0] denom,
    output logic [DATA_WIDTH-1:0] quotient,
    output logic [DATA_WIDTH-1:0] remain
);

    // part_rem[i+1] is the partial remainder entering the stage that
    // produces quotient bit i; part_rem[DATA_WIDTH] is the initial zero.
    logic [DATA_WIDTH-1:0] part_rem [0:DATA_WIDTH];

    assign part_rem[DATA_WIDTH] = '0;

    for (genvar gi = DATA_WIDTH - 1; gi >= 0; gi--) begin : g_stage
        logic [DATA_WIDTH:0] shifted;
        logic [DATA_WIDTH:0] diff;

        // Bring down the next numerator bit and trial-subtract.
        // The partial remainder is always below denom, so the shifted
        // value is below 2*denom and the MSB of the difference is a
        // clean borrow flag.
        assign shifted      = {part_rem[gi+1], numer[gi]};
        assign diff         = shifted - {1'b0, denom};
        assign quotient[gi] = ~diff[DATA_WIDTH];
        assign part_rem[gi] = diff[DATA_WIDTH] ? shifted[DATA_WIDTH-1:0]
                                               : diff[DATA_WIDTH-1:0];
    end

    assign remain = part_rem[0];

endmodule

// File: rtl/lcm_seq.sv
// Multi-cycle GCD/LCM sequencer. Euclid's algorithm runs one remainder
// per cycle on a single shared divider, the same divider then forms
// a/gcd, and lcm = (a/gcd)*b is produced in the multiply state.
module lcm_seq
    import lcm_pkg::*;
#(
    parameter int DATA_WIDTH = LCM_DATA_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   a,
    input  logic [DATA_WIDTH-1:0]   b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   gcd,
    output logic [2*DATA_WIDTH-1:0] lcm,
    output logic                    zero
);

    lcm_state_t state_reg;
    lcm_state_t state_next;

    // Captured operands and Euclid working registers.
    logic [DATA_WIDTH-1:0]   a_reg;
    logic [DATA_WIDTH-1:0]   b_reg;
    logic [DATA_WIDTH-1:0]   x_reg;
    logic [DATA_WIDTH-1:0]   y_reg;
    logic [DATA_WIDTH-1:0]   g_reg;
    logic [DATA_WIDTH-1:0]   q_reg;

    // Presented results.
    logic [DATA_WIDTH-1:0]   gcd_reg;
    logic [2*DATA_WIDTH-1:0] lcm_reg;
    logic                    zero_reg;

    // Shared divider connections.
    logic [DATA_WIDTH-1:0]   div_numer;
    logic [DATA_WIDTH-1:0]   div_denom;
    logic [DATA_WIDTH-1:0]   div_quot;
    logic [DATA_WIDTH-1:0]   div_rem;

    logic                    accept;
    logic                    any_zero;
    logic                    rem_zero;

    // in_ready is forced low while reset is held so nothing can be
    // accepted on the edge reset releases.
    assign in_ready  = (state_reg == IDLE) && !rst;
    assign out_valid = (state_reg == DONE);
    assign accept    = in_valid && in_ready;
    assign any_zero  = (a == '0) || (b == '0);
    assign rem_zero  = (div_rem == '0);

    assign gcd  = gcd_reg;
    assign lcm  = lcm_reg;
    assign zero = zero_reg;

    lcm_seq_div #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_div (
        .numer    (div_numer),
        .denom    (div_denom),
        .quotient (div_quot),
        .remain   (div_rem)
    );

    // Divider operand mux: x/y while iterating, a/g for the quotient,
    // and a harmless 0/1 otherwise so the denominator is never zero.
    always_comb begin
        div_numer = '0;
        div_denom = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
        case (state_reg)
            EUC: begin
                div_numer = x_reg;
                div_denom = y_reg;
            end
            QUO: begin
                div_numer = a_reg;
                div_denom = g_reg;
            end
            default: ;
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = any_zero ? DONE : EUC;
                end
            end
            EUC: begin
                if (rem_zero) begin
                    state_next = QUO;
                end
            end
            QUO:     state_next = MUL;
            MUL:     state_next = DONE;
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Datapath registers: operand capture, Euclid step, quotient,
    // multiply and result hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg    <= '0;
            b_reg    <= '0;
            x_reg    <= '0;
            y_reg    <= '0;
            g_reg    <= '0;
            q_reg    <= '0;
            gcd_reg  <= '0;
            lcm_reg  <= '0;
            zero_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        a_reg <= a;
                        b_reg <= b;
                        if (any_zero) begin
                            // gcd(0,n) = n, lcm is defined as 0 here.
                            gcd_reg  <= a | b;
                            lcm_reg  <= '0;
                            zero_reg <= 1'b1;
                        end else begin
                            x_reg    <= (a > b) ? a : b;
                            y_reg    <= (a > b) ? b : a;
                            zero_reg <= 1'b0;
                        end
                    end
                end
                EUC: begin
                    if (rem_zero) begin
                        g_reg <= y_reg;
                    end else begin
                        x_reg <= y_reg;
                        y_reg <= div_rem;
                    end
                end
                QUO: begin
                    // Exact: g divides a.
                    q_reg <= div_quot;
                end
                MUL: begin
                    // Cannot overflow: q*b <= a*b < 2^(2*DATA_WIDTH).
                    lcm_reg <= {{DATA_WIDTH{1'b0}}, q_reg} *
                               {{DATA_WIDTH{1'b0}}, b_reg};
                    gcd_reg <= g_reg;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lcm_seq.sv
// Directed testbench for lcm_seq: reset, several operand patterns,
// zero operands, backpressure and reset during an operation.
module tb_lcm_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  gcd;
    logic [15:0] lcm;
    logic        zero;

    int n_cmp;
    int n_bad;

    localparam int LAT_LIMIT = 40;

    lcm_seq #(
        .DATA_WIDTH(8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .gcd       (gcd),
        .lcm       (lcm),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one operand pair and count rising edges after the accepting
    // edge until out_valid is seen (sampled on the falling edge).
    // Returns LAT_LIMIT if the result never appears.
    task automatic send_op(input logic [7:0] va, input logic [7:0] vb,
                           output int lat);
        @(negedge clk);
        a        = va;
        b        = vb;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        @(negedge clk);
        while (!out_valid && lat < LAT_LIMIT) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        $display("op a=%0d b=%0d latency=%0d gcd=%0d lcm=%0d zero=%0b",
                 va, vb, lat, gcd, lcm, zero);
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready got=%0b want=0", in_ready); end
        n_cmp++; if (gcd !== 8'd0) begin n_bad++; $display("FAIL reset_gcd got=%0d want=0", gcd); end
        n_cmp++; if (lcm !== 16'd0) begin n_bad++; $display("FAIL reset_lcm got=%0d want=0", lcm); end
        n_cmp++; if (zero !== 1'b0) begin n_bad++; $display("FAIL reset_zero got=%0b want=0", zero); end
        rst = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_release_in_ready got=%0b want=1", in_ready); end
    endtask

    task automatic test_basic();
        int lat;
        out_ready = 1'b1;
        send_op(8'd12, 8'd18, lat);
        n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL basic_latency got=%0d want=4", lat); end
        n_cmp++; if (gcd !== 8'd6) begin n_bad++; $display("FAIL basic_gcd got=%0d want=6", gcd); end
        n_cmp++; if (lcm !== 16'd36) begin n_bad++; $display("FAIL basic_lcm got=%0d want=36", lcm); end
        n_cmp++; if (zero !== 1'b0) begin n_bad++; $display("FAIL basic_zero got=%0b want=0", zero); end
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL basic_in_ready_done got=%0b want=0", in_ready); end
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL basic_out_valid_after got=%0b want=0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL basic_in_ready_after got=%0b want=1", in_ready); end
    endtask

    task automatic test_fibonacci();
        int lat;
        out_ready = 1'b1;
        send_op(8'd233, 8'd144, lat);
        n_cmp++; if (lat !== 13) begin n_bad++; $display("FAIL fib_latency got=%0d want=13", lat); end
        n_cmp++; if (gcd !== 8'd1) begin n_bad++; $display("FAIL fib_gcd got=%0d want=1", gcd); end
        n_cmp++; if (lcm !== 16'd33552) begin n_bad++; $display("FAIL fib_lcm got=%0d want=33552", lcm); end
        n_cmp++; if (zero !== 1'b0) begin n_bad++; $display("FAIL fib_zero got=%0b want=0", zero); end
        @(negedge clk);
    endtask

    task automatic test_zero();
        logic [7:0]  va [2];
        logic [7:0]  vb [2];
        logic [7:0]  eg [2];
        int lat;
        va[0] = 8'd0; vb[0] = 8'd7; eg[0] = 8'd7;
        va[1] = 8'd0; vb[1] = 8'd0; eg[1] = 8'd0;
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            send_op(va[i], vb[i], lat);
            n_cmp++; if (lat !== 0) begin n_bad++; $display("FAIL zero%0d_latency got=%0d want=0", i, lat); end
            n_cmp++; if (gcd !== eg[i]) begin n_bad++; $display("FAIL zero%0d_gcd got=%0d want=%0d", i, gcd, eg[i]); end
            n_cmp++; if (lcm !== 16'd0) begin n_bad++; $display("FAIL zero%0d_lcm got=%0d want=0", i, lcm); end
            n_cmp++; if (zero !== 1'b1) begin n_bad++; $display("FAIL zero%0d_zero got=%0b want=1", i, zero); end
            @(negedge clk);
        end
    endtask

    task automatic test_equal_and_one();
        logic [7:0]  va [3];
        logic [7:0]  vb [3];
        logic [7:0]  eg [3];
        logic [15:0] el [3];
        int lat;
        va[0] = 8'd255; vb[0] = 8'd255; eg[0] = 8'd255; el[0] = 16'd255;
        va[1] = 8'd1;   vb[1] = 8'd200; eg[1] = 8'd1;   el[1] = 16'd200;
        va[2] = 8'd200; vb[2] = 8'd1;   eg[2] = 8'd1;   el[2] = 16'd200;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send_op(va[i], vb[i], lat);
            n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL eq%0d_latency got=%0d want=3", i, lat); end
            n_cmp++; if (gcd !== eg[i]) begin n_bad++; $display("FAIL eq%0d_gcd got=%0d want=%0d", i, gcd, eg[i]); end
            n_cmp++; if (lcm !== el[i]) begin n_bad++; $display("FAIL eq%0d_lcm got=%0d want=%0d", i, lcm, el[i]); end
            n_cmp++; if (zero !== 1'b0) begin n_bad++; $display("FAIL eq%0d_zero got=%0b want=0", i, zero); end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        int lat;
        out_ready = 1'b0;
        send_op(8'd12, 8'd18, lat);
        n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL bp_latency got=%0d want=4", lat); end
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp%0d_out_valid got=%0b want=1", i, out_valid); end
            n_cmp++; if (gcd !== 8'd6) begin n_bad++; $display("FAIL bp%0d_gcd got=%0d want=6", i, gcd); end
            n_cmp++; if (lcm !== 16'd36) begin n_bad++; $display("FAIL bp%0d_lcm got=%0d want=36", i, lcm); end
            n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp%0d_in_ready got=%0b want=0", i, in_ready); end
            if (i == 1) begin
                a        = 8'd3;
                b        = 8'd5;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_release_out_valid got=%0b want=0", out_valid); end
        n_cmp++; if (gcd !== 8'd6) begin n_bad++; $display("FAIL bp_release_gcd got=%0d want=6", gcd); end
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_idle%0d_in_ready got=%0b want=1", i, in_ready); end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_op();
        int lat;
        out_ready = 1'b1;
        @(negedge clk);
        a        = 8'd233;
        b        = 8'd144;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy_out_valid got=%0b want=0", out_valid); end
        n_cmp++; if (gcd !== 8'd6) begin n_bad++; $display("FAIL rstmid_prior_gcd got=%0d want=6", gcd); end
        rst = 1'b1;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_out_valid got=%0b want=0", out_valid); end
        n_cmp++; if (gcd !== 8'd0) begin n_bad++; $display("FAIL rstmid_gcd got=%0d want=0", gcd); end
        n_cmp++; if (lcm !== 16'd0) begin n_bad++; $display("FAIL rstmid_lcm got=%0d want=0", lcm); end
        n_cmp++; if (zero !== 1'b0) begin n_bad++; $display("FAIL rstmid_zero got=%0b want=0", zero); end
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rstmid_in_ready got=%0b want=0", in_ready); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_release_in_ready got=%0b want=1", in_ready); end
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_idle_out_valid got=%0b want=0", out_valid); end
        send_op(8'd4, 8'd6, lat);
        n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL rstmid_next_latency got=%0d want=4", lat); end
        n_cmp++; if (gcd !== 8'd2) begin n_bad++; $display("FAIL rstmid_next_gcd got=%0d want=2", gcd); end
        n_cmp++; if (lcm !== 16'd12) begin n_bad++; $display("FAIL rstmid_next_lcm got=%0d want=12", lcm); end
        @(negedge clk);
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 8'd0;
        b         = 8'd0;

        test_reset();
        test_basic();
        test_fibonacci();
        test_zero();
        test_equal_and_one();
        test_backpressure();
        test_reset_mid_op();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
